// File: rtl/issue_scheduler_if.sv
// Dispatch, writeback and issue bundle of the issue scheduler.
// The master drives dispatch, writeback and issue_ready; the slave is the scheduler.
interface issue_scheduler_if #(
    parameter int QUEUE_DEPTH          = 8,
    parameter int DISPATCH_WIDTH       = 2,
    parameter int WB_WIDTH             = 2,
    parameter int PHYS_REGS_ADDR_WIDTH = 7,
    parameter int PAYLOAD_WIDTH        = 32
);
    localparam int PRA = PHYS_REGS_ADDR_WIDTH;
    localparam int CW  = $clog2(QUEUE_DEPTH + 1);

    logic                                             flush;
    logic [DISPATCH_WIDTH-1:0]                        dispatch_valid;
    logic                                             dispatch_ready;
    logic [DISPATCH_WIDTH-1:0][PRA-1:0]               dispatch_op1_tag;
    logic [DISPATCH_WIDTH-1:0]                        dispatch_op1_valid;
    logic [DISPATCH_WIDTH-1:0][31:0]                  dispatch_op2;
    logic [DISPATCH_WIDTH-1:0]                        dispatch_op2_valid;
    logic [DISPATCH_WIDTH-1:0]                        dispatch_op2_is_imm;
    logic [DISPATCH_WIDTH-1:0][PRA-1:0]               dispatch_rd;
    logic [DISPATCH_WIDTH-1:0][PAYLOAD_WIDTH-1:0]     dispatch_payload;
    logic [WB_WIDTH-1:0]                              wb_valid;
    logic [WB_WIDTH-1:0][PRA-1:0]                     wb_tag;
    logic                                             issue_valid;
    logic                                             issue_ready;
    logic [PRA-1:0]                                   issue_op1_tag;
    logic [31:0]                                      issue_op2;
    logic                                             issue_op2_is_imm;
    logic [PRA-1:0]                                   issue_rd;
    logic [PAYLOAD_WIDTH-1:0]                         issue_payload;
    logic [CW-1:0]                                    count;

    modport master (
        output flush, dispatch_valid, dispatch_op1_tag, dispatch_op1_valid, dispatch_op2,
               dispatch_op2_valid, dispatch_op2_is_imm, dispatch_rd, dispatch_payload,
               wb_valid, wb_tag, issue_ready,
        input  dispatch_ready, issue_valid, issue_op1_tag, issue_op2, issue_op2_is_imm,
               issue_rd, issue_payload, count
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_op1_tag, dispatch_op1_valid, dispatch_op2,
               dispatch_op2_valid, dispatch_op2_is_imm, dispatch_rd, dispatch_payload,
               wb_valid, wb_tag, issue_ready,
        output dispatch_ready, issue_valid, issue_op1_tag, issue_op2, issue_op2_is_imm,
               issue_rd, issue_payload, count
    );
endinterface

// File: rtl/issue_scheduler.sv
// Compacting out-of-order issue queue: index 0 is oldest, operands woken by writeback
// broadcasts, the oldest fully-ready entry is offered to execute each cycle.
module issue_scheduler #(
    parameter int QUEUE_DEPTH          = 8,
    parameter int DISPATCH_WIDTH       = 2,
    parameter int WB_WIDTH             = 2,
    parameter int PHYS_REGS_ADDR_WIDTH = 7,
    parameter int PAYLOAD_WIDTH        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    issue_scheduler_if.slave   bus
);
    localparam int PRA = PHYS_REGS_ADDR_WIDTH;
    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int IW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    typedef struct packed {
        logic [PRA-1:0]           op1_tag;
        logic                     op1_valid;
        logic [31:0]              op2;
        logic                     op2_valid;
        logic                     op2_is_imm;
        logic [PRA-1:0]           rd;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } entry_t;

    logic [QUEUE_DEPTH-1:0] valid_q, valid_d;
    entry_t                 entry_q [QUEUE_DEPTH];
    entry_t                 entry_d [QUEUE_DEPTH];
    entry_t                 disp_e  [DISPATCH_WIDTH];
    logic [CW-1:0]          count_q, count_d;
    logic [QUEUE_DEPTH-1:0] rdy;
    logic [IW-1:0]          sel;
    logic                   any_rdy;
    logic                   issue_fire;
    logic                   disp_ok;

    function automatic logic tag_hit(input logic [PRA-1:0]               tag,
                                     input logic [WB_WIDTH-1:0]          wbv,
                                     input logic [WB_WIDTH-1:0][PRA-1:0] wbt);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_WIDTH; w++) begin
            hit = hit | (wbv[w] && (wbt[w] == tag));
        end
        return hit;
    endfunction

    function automatic entry_t wake(input entry_t                       e,
                                    input logic [WB_WIDTH-1:0]          wbv,
                                    input logic [WB_WIDTH-1:0][PRA-1:0] wbt);
        entry_t r;
        r = e;
        if (tag_hit(e.op1_tag, wbv, wbt)) r.op1_valid = 1'b1;
        // Immediates carry data in op2, so they must never be mistaken for a tag.
        if (!e.op2_is_imm && tag_hit(e.op2[PRA-1:0], wbv, wbt)) r.op2_valid = 1'b1;
        return r;
    endfunction

    always_comb begin
        rdy = '0;
        sel = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            rdy[i] = valid_q[i] && entry_q[i].op1_valid && entry_q[i].op2_valid;
        end
        for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) sel = IW'(i);
        end
    end

    assign any_rdy    = |rdy;
    assign issue_fire = any_rdy && bus.issue_ready;
    assign disp_ok    = (count_q <= CW'(QUEUE_DEPTH - DISPATCH_WIDTH));

    assign bus.dispatch_ready   = disp_ok;
    assign bus.count            = count_q;
    assign bus.issue_valid      = any_rdy;
    assign bus.issue_op1_tag    = any_rdy ? entry_q[sel].op1_tag    : '0;
    assign bus.issue_op2        = any_rdy ? entry_q[sel].op2        : '0;
    assign bus.issue_op2_is_imm = any_rdy ? entry_q[sel].op2_is_imm : 1'b0;
    assign bus.issue_rd         = any_rdy ? entry_q[sel].rd         : '0;
    assign bus.issue_payload    = any_rdy ? entry_q[sel].payload    : '0;

    // Incoming ops see this cycle's broadcasts so a same-cycle wakeup is not lost.
    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            disp_e[k] = wake(entry_t'{
                op1_tag:    bus.dispatch_op1_tag[k],
                op1_valid:  bus.dispatch_op1_valid[k],
                op2:        bus.dispatch_op2[k],
                op2_valid:  bus.dispatch_op2_valid[k],
                op2_is_imm: bus.dispatch_op2_is_imm[k],
                rd:         bus.dispatch_rd[k],
                payload:    bus.dispatch_payload[k]
            }, bus.wb_valid, bus.wb_tag);
        end
    end

    always_comb begin
        int pos;
        int n_acc;
        valid_d = valid_q;
        count_d = count_q;
        for (int i = 0; i < QUEUE_DEPTH; i++) entry_d[i] = entry_q[i];

        for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
            if (issue_fire && (i >= int'(sel))) begin
                valid_d[i] = valid_q[i+1];
                entry_d[i] = wake(entry_q[i+1], bus.wb_valid, bus.wb_tag);
            end else begin
                entry_d[i] = wake(entry_q[i], bus.wb_valid, bus.wb_tag);
            end
        end
        // The selected index never exceeds the top slot, so an issue always vacates it.
        if (issue_fire) valid_d[QUEUE_DEPTH-1] = 1'b0;
        else entry_d[QUEUE_DEPTH-1] = wake(entry_q[QUEUE_DEPTH-1], bus.wb_valid, bus.wb_tag);

        pos   = int'(count_q) - (issue_fire ? 1 : 0);
        n_acc = 0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (bus.dispatch_valid[k] && disp_ok) begin
                for (int e = 0; e < QUEUE_DEPTH; e++) begin
                    if (e == pos) begin
                        valid_d[e] = 1'b1;
                        entry_d[e] = disp_e[k];
                    end
                end
                pos   = pos + 1;
                n_acc = n_acc + 1;
            end
        end
        count_d = CW'(int'(count_q) + n_acc - (issue_fire ? 1 : 0));

        if (bus.flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload fields are qualified by valid_q and need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) entry_q[i] <= entry_d[i];
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model of the scheduler.
module tb_issue_scheduler;
    localparam int D   = 8;
    localparam int DW  = 2;
    localparam int WB  = 2;
    localparam int PRA = 7;
    localparam int PW  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_scheduler_if #(.QUEUE_DEPTH(D), .DISPATCH_WIDTH(DW), .WB_WIDTH(WB),
                         .PHYS_REGS_ADDR_WIDTH(PRA), .PAYLOAD_WIDTH(PW)) bus ();

    issue_scheduler #(.QUEUE_DEPTH(D), .DISPATCH_WIDTH(DW), .WB_WIDTH(WB),
                      .PHYS_REGS_ADDR_WIDTH(PRA), .PAYLOAD_WIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]               dv;
        logic [1:0][PRA-1:0]      t1;
        logic [1:0]               v1;
        logic [1:0][31:0]         op2;
        logic [1:0]               v2;
        logic [1:0]               imm;
        logic [1:0][PRA-1:0]      rd;
        logic [1:0][PW-1:0]       pl;
        logic [1:0]               wbv;
        logic [1:0][PRA-1:0]      wbt;
        logic                     ir;
        logic                     fl;
    } stim_t;

    typedef struct packed {
        logic [PRA-1:0] t1;
        logic           v1;
        logic [31:0]    op2;
        logic           v2;
        logic           imm;
        logic [PRA-1:0] rd;
        logic [PW-1:0]  pl;
    } op_t;

    typedef struct {
        stim_t       s;
        int          ecount;
        bit          eiv;
        bit          edr;
        bit          cpl;
        logic [31:0] epl;
        logic [31:0] eop2;
    } vec_t;

    op_t   mq[$];
    vec_t  tbl[$];
    stim_t cur;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [PRA-1:0] t, input stim_t s);
        return (s.wbv[0] && s.wbt[0] == t) || (s.wbv[1] && s.wbt[1] == t);
    endfunction

    function automatic op_t wake(input op_t o, input stim_t s);
        op_t r = o;
        if (hit(o.t1, s)) r.v1 = 1'b1;
        if (!o.imm && hit(o.op2[PRA-1:0], s)) r.v2 = 1'b1;
        return r;
    endfunction

    function automatic int first_ready();
        foreach (mq[i]) if (mq[i].v1 && mq[i].v2) return i;
        return -1;
    endfunction

    function automatic op_t mk(input stim_t s, input int k);
        op_t o;
        o.t1 = s.t1[k]; o.v1 = s.v1[k]; o.op2 = s.op2[k]; o.v2 = s.v2[k];
        o.imm = s.imm[k]; o.rd = s.rd[k]; o.pl = s.pl[k];
        return o;
    endfunction

    function automatic stim_t put(input stim_t s, input int k, input int t1, input bit v1,
                                  input logic [31:0] op2, input bit v2, input bit imm,
                                  input int rd, input logic [31:0] pl);
        stim_t r = s;
        r.dv[k] = 1'b1; r.t1[k] = PRA'(t1); r.v1[k] = v1; r.op2[k] = op2;
        r.v2[k] = v2; r.imm[k] = imm; r.rd[k] = PRA'(rd); r.pl[k] = pl;
        return r;
    endfunction

    function automatic stim_t wbs(input stim_t s, input int w, input int tag);
        stim_t r = s;
        r.wbv[w] = 1'b1; r.wbt[w] = PRA'(tag);
        return r;
    endfunction

    function automatic stim_t idle(input bit ir);
        stim_t r = '0;
        r.ir = ir;
        return r;
    endfunction

    function automatic stim_t rnd();
        stim_t       s = '0;
        int          d;
        logic [31:0] r;
        d = int'($urandom_range(0, 2));
        s.dv = (d == 0) ? 2'b00 : (d == 1) ? 2'b01 : 2'b11;
        for (int k = 0; k < DW; k++) begin
            s.t1[k]  = PRA'($urandom_range(0, 7));
            s.v1[k]  = ($urandom_range(0, 2) != 0);
            s.imm[k] = ($urandom_range(0, 1) == 1);
            r = $urandom;
            if (s.imm[k]) begin
                s.v2[k] = 1'b1;
            end else begin
                r[PRA-1:0] = PRA'($urandom_range(0, 7));
                s.v2[k] = ($urandom_range(0, 2) != 0);
            end
            s.op2[k] = r;
            s.rd[k]  = PRA'($urandom_range(0, 127));
            s.pl[k]  = $urandom;
        end
        s.wbv = 2'($urandom_range(0, 3));
        for (int w = 0; w < WB; w++) s.wbt[w] = PRA'($urandom_range(0, 7));
        s.ir = ($urandom_range(0, 3) != 0);
        s.fl = ($urandom_range(0, 59) == 0);
        return s;
    endfunction

    task automatic model_check();
        int f;
        f = first_ready();
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("dispatch_ready", 64'(bus.dispatch_ready), 64'(mq.size() <= D - DW));
        chk("issue_valid", 64'(bus.issue_valid), 64'(f >= 0));
        if (f >= 0) begin
            chk("issue_op1_tag", 64'(bus.issue_op1_tag), 64'(mq[f].t1));
            chk("issue_op2", 64'(bus.issue_op2), 64'(mq[f].op2));
            chk("issue_op2_is_imm", 64'(bus.issue_op2_is_imm), 64'(mq[f].imm));
            chk("issue_rd", 64'(bus.issue_rd), 64'(mq[f].rd));
            chk("issue_payload", 64'(bus.issue_payload), 64'(mq[f].pl));
        end
    endtask

    task automatic model_update(input stim_t s);
        int f;
        bit acc;
        if (s.fl) begin
            mq.delete();
            return;
        end
        f   = first_ready();
        acc = (mq.size() <= D - DW);
        foreach (mq[i]) mq[i] = wake(mq[i], s);
        if (f >= 0 && s.ir) mq.delete(f);
        for (int k = 0; k < DW; k++) begin
            if (acc && s.dv[k]) mq.push_back(wake(mk(s, k), s));
        end
    endtask

    task automatic apply(input stim_t s);
        cur = s;
        bus.dispatch_valid      = s.dv;
        bus.dispatch_op1_tag    = s.t1;
        bus.dispatch_op1_valid  = s.v1;
        bus.dispatch_op2        = s.op2;
        bus.dispatch_op2_valid  = s.v2;
        bus.dispatch_op2_is_imm = s.imm;
        bus.dispatch_rd         = s.rd;
        bus.dispatch_payload    = s.pl;
        bus.wb_valid            = s.wbv;
        bus.wb_tag              = s.wbt;
        bus.issue_ready         = s.ir;
        bus.flush               = s.fl;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(cur);
        @(negedge clk);
    endtask

    task automatic add_row(input stim_t s, input int ec, input bit eiv, input bit edr,
                           input bit cpl, input logic [31:0] epl, input logic [31:0] eop2);
        vec_t v;
        v.s = s; v.ecount = ec; v.eiv = eiv; v.edr = edr;
        v.cpl = cpl; v.epl = epl; v.eop2 = eop2;
        tbl.push_back(v);
    endtask

    initial begin
        stim_t s;

        // Two immediate ops issued in order, then fill to full and drain across the threshold.
        s = idle(1'b1);
        s = put(s, 0, 3, 1, 32'h10, 1, 1, 1, 32'hA0);
        s = put(s, 1, 4, 1, 32'h10, 1, 1, 2, 32'hB0);
        add_row(s,           0, 0, 1, 0, 0,      0);
        add_row(idle(1'b1),  2, 1, 1, 1, 32'hA0, 32'h10);
        add_row(idle(1'b1),  1, 1, 1, 1, 32'hB0, 32'h10);
        add_row(idle(1'b0),  0, 0, 1, 0, 0,      0);
        for (int p = 0; p < 4; p++) begin
            s = idle(1'b0);
            s = put(s, 0, 0, 1, 32'h20 + 2 * p,     1, 1, 10, 32'hC0 + 2 * p);
            s = put(s, 1, 0, 1, 32'h20 + 2 * p + 1, 1, 1, 11, 32'hC0 + 2 * p + 1);
            add_row(s, 2 * p, (p != 0), 1, (p != 0), 32'hC0, 32'h20);
        end
        add_row(idle(1'b1), 8, 1, 0, 1, 32'hC0, 32'h20);
        add_row(idle(1'b0), 7, 1, 0, 1, 32'hC1, 32'h21);
        s = put(idle(1'b1), 0, 0, 1, 32'h77, 1, 1, 12, 32'hDD);
        add_row(s,          7, 1, 0, 1, 32'hC1, 32'h21);
        add_row(idle(1'b1), 6, 1, 1, 1, 32'hC2, 32'h22);
        add_row(idle(1'b0), 5, 1, 1, 1, 32'hC3, 32'h23);

        apply(idle(1'b0));
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("reset_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
        chk("reset_issue_payload", 64'(bus.issue_payload), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].s);
            chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'(tbl[i].ecount));
            chk($sformatf("vec%0d_issue_valid", i), 64'(bus.issue_valid), 64'(tbl[i].eiv));
            chk($sformatf("vec%0d_dispatch_ready", i), 64'(bus.dispatch_ready), 64'(tbl[i].edr));
            if (tbl[i].cpl) begin
                chk($sformatf("vec%0d_payload", i), 64'(bus.issue_payload), 64'(tbl[i].epl));
                chk($sformatf("vec%0d_op2", i), 64'(bus.issue_op2), 64'(tbl[i].eop2));
                chk($sformatf("vec%0d_is_imm", i), 64'(bus.issue_op2_is_imm), 64'd1);
            end
            tick();
        end

        // Asynchronous reset with 5 entries held, asserted away from any clock edge.
        apply(idle(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("arst_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
        chk("arst_issue_op2", 64'(bus.issue_op2), 64'd0);
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Wakeup latency: op1 tag 5 woken at N, op2 tag 9 at N+2, first issue at N+3.
        s = idle(1'b1);
        s = put(s, 0, 5,  0, 32'h9, 0, 0, 1, 32'h3A);
        s = put(s, 1, 20, 0, 32'h9, 1, 1, 2, 32'h3B);
        apply(s); tick();
        apply(wbs(idle(1'b1), 0, 5));
        chk("wake_n", 64'(bus.issue_valid), 64'd0); tick();
        apply(idle(1'b1));
        chk("wake_n1", 64'(bus.issue_valid), 64'd0); tick();
        apply(wbs(idle(1'b1), 1, 9));
        chk("wake_n2", 64'(bus.issue_valid), 64'd0); tick();
        apply(idle(1'b1));
        chk("wake_n3_valid", 64'(bus.issue_valid), 64'd1);
        chk("wake_n3_payload", 64'(bus.issue_payload), 64'h3A); tick();
        apply(idle(1'b1));
        chk("imm_no_false_wake", 64'(bus.issue_valid), 64'd0); tick();
        apply(wbs(idle(1'b1), 0, 20)); tick();
        apply(idle(1'b1));
        chk("imm_op2_kept", 64'(bus.issue_op2), 64'h9);
        chk("imm_payload", 64'(bus.issue_payload), 64'h3B); tick();

        // Same-cycle bypass of a broadcast into a dispatching op.
        s = wbs(put(idle(1'b0), 0, 12, 0, 32'h44, 1, 1, 3, 32'h4A), 1, 12);
        apply(s);
        chk("bypass_before", 64'(bus.issue_valid), 64'd0); tick();
        apply(idle(1'b1));
        chk("bypass_valid", 64'(bus.issue_valid), 64'd1);
        chk("bypass_payload", 64'(bus.issue_payload), 64'h4A); tick();

        // Oldest-first under a stall, then compaction moves old entry 2 down to index 1.
        s = idle(1'b0);
        s = put(s, 0, 1,  1, 32'h61, 1, 1, 4, 32'h6A);
        s = put(s, 1, 30, 0, 32'h62, 1, 1, 5, 32'h6B);
        apply(s); tick();
        apply(put(idle(1'b0), 0, 2, 1, 32'h63, 1, 1, 6, 32'h6C)); tick();
        for (int c = 0; c < 3; c++) begin
            apply(idle(1'b0));
            chk($sformatf("stall%0d_payload", c), 64'(bus.issue_payload), 64'h6A);
            tick();
        end
        apply(idle(1'b1));
        chk("oldest_payload", 64'(bus.issue_payload), 64'h6A); tick();
        apply(idle(1'b1));
        chk("second_payload", 64'(bus.issue_payload), 64'h6C);
        chk("second_count", 64'(bus.count), 64'd2); tick();

        // Flush drops the remaining waiting entry and ignores same-cycle dispatch.
        s = idle(1'b0);
        s.fl = 1'b1;
        apply(put(s, 0, 0, 1, 32'h1, 1, 1, 0, 32'hEE)); tick();
        apply(idle(1'b0));
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_issue_valid", 64'(bus.issue_valid), 64'd0); tick();

        for (int n = 0; n < 600; n++) begin
            apply(rnd());
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
